// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: states, opcodes, mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_ILL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_R31  = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/ALUOp_Mod.svh
// ALUOp operation-class encodings shared by the controller and the ALU control unit.
`ifndef ALUOP_MOD_SVH
`define ALUOP_MOD_SVH
`define ALUOp_WIRENUM 4
`define ALUOp_ADD  4'd0
`define ALUOp_ADDU 4'd1
`define ALUOp_SUB  4'd2
`define ALUOp_SLT  4'd3
`define ALUOp_SLTU 4'd4
`define ALUOp_AND  4'd5
`define ALUOp_OR   4'd6
`define ALUOp_XOR  4'd7
`define ALUOp_R    4'd8
`endif

// File: rtl/mc_opdecode.sv
// Opcode classifier: instruction class plus the ALUOp/extension choice for I-type ALU ops.
`include "ALUOp_Mod.svh"

module mc_opdecode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]                i_opcode,
  output iclass_e                   o_class,
  output logic [`ALUOp_WIRENUM-1:0] o_i_aluop,
  output logic                      o_extop
);

  always_comb begin
    o_class   = CLS_ILL;
    o_i_aluop = `ALUOp_ADD;
    o_extop   = 1'b1;
    case (i_opcode)
      OP_RTYPE: o_class = CLS_R;
      OP_ADDI:  begin o_class = CLS_I; o_i_aluop = `ALUOp_ADD;  end
      OP_ADDIU: begin o_class = CLS_I; o_i_aluop = `ALUOp_ADDU; end
      OP_SLTI:  begin o_class = CLS_I; o_i_aluop = `ALUOp_SLT;  end
      OP_SLTIU: begin o_class = CLS_I; o_i_aluop = `ALUOp_SLTU; end
      // Logical immediates are zero-extended.
      OP_ANDI:  begin o_class = CLS_I; o_i_aluop = `ALUOp_AND; o_extop = 1'b0; end
      OP_ORI:   begin o_class = CLS_I; o_i_aluop = `ALUOp_OR;  o_extop = 1'b0; end
      OP_XORI:  begin o_class = CLS_I; o_i_aluop = `ALUOp_XOR; o_extop = 1'b0; end
      OP_LW:    o_class = CLS_LW;
      OP_SW:    o_class = CLS_SW;
      OP_BEQ:   o_class = CLS_BEQ;
      OP_BNE:   o_class = CLS_BNE;
      OP_J:     o_class = CLS_J;
      OP_JAL:   o_class = CLS_JAL;
      default:  o_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: registered state, combinational control outputs.
`include "ALUOp_Mod.svh"

module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [5:0]                opcode,
  input  logic                      zero,
  input  logic                      mem_ready,
  output logic                      PCWr,
  output logic                      IRWr,
  output logic                      IorD,
  output logic                      MemRd,
  output logic                      MemWr,
  output logic                      RegWr,
  output logic [1:0]                RegDst,
  output logic [1:0]                MemtoReg,
  output logic                      ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [`ALUOp_WIRENUM-1:0] ALUOp,
  output logic [1:0]                PCSrc,
  output logic                      ExtOp,
  output logic                      illegal,
  output state_e                    o_dbg_state
);

  state_e                    r_state;
  state_e                    w_next;
  logic                      r_wb_rd;
  iclass_e                   w_class;
  logic [`ALUOp_WIRENUM-1:0] w_i_aluop;
  logic                      w_i_extop;
  logic                      w_pcwr, w_irwr, w_memrd, w_memwr, w_regwr, w_illegal;

  mc_opdecode u_opdecode (
    .i_opcode  (opcode),
    .o_class   (w_class),
    .o_i_aluop (w_i_aluop),
    .o_extop   (w_i_extop)
  );

  // r_wb_rd remembers R vs I so WB_ALU does not depend on opcode still being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_wb_rd <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_wb_rd <= (w_class == CLS_R);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pcwr    = 1'b0;
    w_irwr    = 1'b0;
    w_memrd   = 1'b0;
    w_memwr   = 1'b0;
    w_regwr   = 1'b0;
    w_illegal = 1'b0;
    IorD      = 1'b0;
    RegDst    = REGDST_RT;
    MemtoReg  = MEMTOREG_ALU;
    ALUSrcA   = 1'b0;
    ALUSrcB   = ALUSRCB_RT;
    ALUOp     = `ALUOp_ADD;
    PCSrc     = PCSRC_ALU;
    ExtOp     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memrd = 1'b1;
        ALUSrcB = ALUSRCB_FOUR;
        ALUOp   = `ALUOp_ADDU;
        if (mem_ready) begin
          w_irwr = 1'b1;
          w_pcwr = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = ALUSRCB_BROFF;
        case (w_class)
          CLS_R:            w_next = S_EXEC_R;
          CLS_I:            w_next = S_EXEC_I;
          CLS_LW, CLS_SW:   w_next = S_MEM_ADDR;
          CLS_BEQ, CLS_BNE: w_next = S_BRANCH;
          CLS_J, CLS_JAL:   w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = `ALUOp_R;
        w_next  = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
        ALUOp   = w_i_aluop;
        ExtOp   = w_i_extop;
        w_next  = S_WB_ALU;
      end
      S_WB_ALU: begin
        w_regwr = 1'b1;
        RegDst  = r_wb_rd ? REGDST_RD : REGDST_RT;
        w_next  = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
        ExtOp   = 1'b1;
        w_next  = (w_class == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        w_memrd = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        w_regwr  = 1'b1;
        MemtoReg = MEMTOREG_MDR;
        w_next   = S_FETCH;
      end
      S_MEM_WR: begin
        IorD    = 1'b1;
        w_memwr = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = `ALUOp_SUB;
        PCSrc   = PCSRC_ALUOUT;
        w_pcwr  = (w_class == CLS_BNE) ? ~zero : zero;
        w_next  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc  = PCSRC_JUMP;
        w_pcwr = 1'b1;
        if (w_class == CLS_JAL) begin
          w_regwr  = 1'b1;
          RegDst   = REGDST_R31;
          MemtoReg = MEMTOREG_PC;
        end
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset parks the FSM in FETCH, whose MemRd must still be suppressed while rst_n is low.
  assign PCWr        = w_pcwr    & rst_n;
  assign IRWr        = w_irwr    & rst_n;
  assign MemRd       = w_memrd   & rst_n;
  assign MemWr       = w_memwr   & rst_n;
  assign RegWr       = w_regwr   & rst_n;
  assign illegal     = w_illegal & rst_n;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: per-instruction cycle scripts from a class-level model, checked every cycle.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  localparam int W = 25;
  localparam logic [3:0] A_ADD = 4'd0, A_ADDU = 4'd1, A_SUB = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4;
  localparam logic [3:0] A_AND = 4'd5, A_OR = 4'd6, A_XOR = 4'd7, A_R = 4'd8;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwr, irwr, iord, memrd, memwr, regwr;
    logic [1:0] regdst, memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       extop, illegal;
  } cw_t;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic       PCWr, IRWr, IorD, MemRd, MemWr, RegWr, ALUSrcA, ExtOp, illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
  logic [3:0] ALUOp;
  state_e     dbg_state;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWr(PCWr), .IRWr(IRWr), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr), .RegWr(RegWr),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .ExtOp(ExtOp), .illegal(illegal), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [5:0]   op_q[$];
  logic         rdy_q[$];
  logic         zero_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic rb();
    return ($urandom & 32'd1) == 32'd1;
  endfunction

  function automatic cw_t base(input state_e s);
    cw_t c;
    c       = '0;
    c.st    = s;
    c.aluop = A_ADD;
    return c;
  endfunction

  function automatic logic [W-1:0] observed();
    cw_t o;
    o.st = dbg_state;     o.pcwr = PCWr;      o.irwr = IRWr;      o.iord = IorD;
    o.memrd = MemRd;      o.memwr = MemWr;    o.regwr = RegWr;    o.regdst = RegDst;
    o.memtoreg = MemtoReg; o.srca = ALUSrcA;  o.srcb = ALUSrcB;   o.aluop = ALUOp;
    o.pcsrc = PCSrc;      o.extop = ExtOp;    o.illegal = illegal;
    return o;
  endfunction

  // Reference model: instruction kind from the opcode table
  // 0 R, 1 I-ALU, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 jal, 8 unsupported
  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110: return 1;
      6'b100011: return 2;
      6'b101011: return 3;
      6'b000100: return 4;
      6'b000101: return 5;
      6'b000010: return 6;
      6'b000011: return 7;
      default:   return 8;
    endcase
  endfunction

  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    logic [3:0] tbl[8];
    tbl = '{A_ADD, A_ADDU, A_SLT, A_SLTU, A_AND, A_OR, A_XOR, A_ADD};
    return tbl[op[2:0]];
  endfunction

  // Driver tasks
  task automatic push(input cw_t c, input logic [5:0] op, input logic rdy, input logic z);
    exp_q.push_back(c);
    op_q.push_back(op);
    rdy_q.push_back(rdy);
    zero_q.push_back(z);
  endtask

  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw, input logic bz);
    cw_t c;
    int  k;
    k = kind_of(op);
    for (int i = 0; i <= fw; i++) begin
      c = base(S_FETCH);
      c.memrd = 1'b1; c.srcb = 2'b01; c.aluop = A_ADDU;
      c.irwr = (i == fw); c.pcwr = (i == fw);
      push(c, 6'($urandom), i == fw, rb());
    end
    c = base(S_DECODE);
    c.srcb = 2'b11;
    c.illegal = (k == 8);
    push(c, op, rb(), rb());
    case (k)
      0, 1: begin
        c = base(k == 0 ? S_EXEC_R : S_EXEC_I);
        c.srca = 1'b1;
        c.srcb = (k == 0) ? 2'b00 : 2'b10;
        c.aluop = (k == 0) ? A_R : imm_aluop(op);
        c.extop = (k == 1) && (op[2:0] < 3'd4);
        push(c, op, rb(), rb());
        c = base(S_WB_ALU);
        c.regwr = 1'b1;
        c.regdst = (k == 0) ? 2'b01 : 2'b00;
        push(c, op, rb(), rb());
      end
      2, 3: begin
        c = base(S_MEM_ADDR);
        c.srca = 1'b1; c.srcb = 2'b10; c.extop = 1'b1;
        push(c, op, rb(), rb());
        for (int i = 0; i <= mw; i++) begin
          c = base(k == 2 ? S_MEM_RD : S_MEM_WR);
          c.iord = 1'b1;
          c.memrd = (k == 2);
          c.memwr = (k == 3);
          push(c, op, i == mw, rb());
        end
        if (k == 2) begin
          c = base(S_WB_MEM);
          c.regwr = 1'b1; c.memtoreg = 2'b01;
          push(c, op, rb(), rb());
        end
      end
      4, 5: begin
        c = base(S_BRANCH);
        c.srca = 1'b1; c.aluop = A_SUB; c.pcsrc = 2'b01;
        c.pcwr = (k == 4) ? bz : ~bz;
        push(c, op, rb(), bz);
      end
      6, 7: begin
        c = base(S_JUMP);
        c.pcsrc = 2'b10; c.pcwr = 1'b1;
        if (k == 7) begin
          c.regwr = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10;
        end
        push(c, op, rb(), rb());
      end
      default: ;
    endcase
  endtask

  task automatic play(input int n);
    int done;
    done = 0;
    while (exp_q.size() > 0 && (n < 0 || done < n)) begin
      @(negedge clk);
      opcode    = op_q.pop_front();
      mem_ready = rdy_q.pop_front();
      zero      = zero_q.pop_front();
      #1;
      cyc++;
      chk($sformatf("cyc%0d", cyc), observed(), exp_q.pop_front());
      done++;
    end
  endtask

  task automatic gen_random(input int count);
    logic [5:0] ops[14];
    logic [5:0] op;
    ops = '{6'b000000, 6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
            6'b001110, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011};
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 13)];
      gen_instr(op, (rb() ? 0 : $urandom_range(0, 3)), $urandom_range(0, 3), rb());
      play(-1);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_strobes", {PCWr, IRWr, MemRd, MemWr, RegWr, illegal}, 6'b0);
    chk("rst_state", dbg_state, S_FETCH);
    @(posedge clk); #1;
    chk("rst_hold_state", dbg_state, S_FETCH);
    chk("rst_hold_strobes", {PCWr, IRWr, MemRd, MemWr, RegWr, illegal}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    chk("rel_fetch_memrd", {dbg_state, MemRd, PCWr}, {S_FETCH, 1'b1, 1'b0});

    // Directed: R-type, lw with 3 waits, beq/bne taken-zero, jal, unsupported, j, sw, ori
    gen_instr(6'b000000, 0, 0, 1'b0); play(-1);
    gen_instr(6'b100011, 0, 3, 1'b0); play(-1);
    gen_instr(6'b000100, 0, 0, 1'b1); play(-1);
    gen_instr(6'b000101, 0, 0, 1'b1); play(-1);
    gen_instr(6'b000011, 0, 0, 1'b0); play(-1);
    gen_instr(6'b111111, 0, 0, 1'b0); play(-1);
    gen_instr(6'b000010, 2, 0, 1'b0); play(-1);
    gen_instr(6'b101011, 1, 2, 1'b0); play(-1);
    gen_instr(6'b001101, 0, 0, 1'b0); play(-1);

    gen_random(120);

    // Reset asserted while a store is waiting on memory
    gen_instr(6'b101011, 0, 5, 1'b0);
    play(4);
    exp_q.delete(); op_q.delete(); rdy_q.delete(); zero_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_memwr", MemWr, 1'b0);
    chk("midrst_state", dbg_state, S_FETCH);
    chk("midrst_strobes", {PCWr, IRWr, MemRd, MemWr, RegWr, illegal}, 6'b0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_hold", {dbg_state, PCWr, IRWr, MemRd}, {S_FETCH, 3'b000});
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    chk("midrst_release", {dbg_state, MemRd, PCWr, IRWr}, {S_FETCH, 3'b100});

    gen_random(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-low; the block SHALL use ports clk and rst_n.
REQ-002 Parameters: none; ALUOp width SHALL be `ALUOp_WIRENUM.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 opcode  input  6  instruction opcode, valid from DECODE onward.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current access in this cycle.
REQ-008 PCWr  output  1  PC write enable.
REQ-009 IRWr  output  1  instruction register write enable.
REQ-010 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 MemRd  output  1  memory read request.
REQ-012 MemWr  output  1  memory write request.
REQ-013 RegWr  output  1  register file write enable.
REQ-014 RegDst  output  2  write register select: 00 = rt, 01 = rd, 10 = r31.
REQ-015 MemtoReg  output  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-016 ALUSrcA  output  1  ALU A input: 0 = PC, 1 = rs.
REQ-017 ALUSrcB  output  2  ALU B input: 00 = rt, 01 = 4, 10 = extended imm, 11 = sext(imm)<<2.
REQ-018 ALUOp  output  `ALUOp_WIRENUM  operation class, consumed by ALUCU.
REQ-019 PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-020 ExtOp  output  1  immediate extension: 1 = sign, 0 = zero.
REQ-021 illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-022 States: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP. State is registered; outputs are combinational from state, qualified by mem_ready and zero where stated. Any output not listed for a state is 0; ALUOp defaults to `ALUOp_ADD.
REQ-023 FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=`ALUOp_ADDU, PCSrc=00. While mem_ready=0: hold, IRWr=PCWr=0. When mem_ready=1: IRWr=PCWr=1 for that cycle only, then go to DECODE.
REQ-024 DECODE (one cycle): ALUSrcA=0, ALUSrcB=11, ALUOp=`ALUOp_ADD (branch target into ALUOut).
- Next state: 000000 -> EXEC_R; 001000/001001/001010/001011/001100/001101/001110 -> EXEC_I; 100011/101011 -> MEM_ADDR; 000100/000101 -> BRANCH; 000010/000011 -> JUMP.
- Any other opcode -> FETCH with illegal=1 for that cycle.
REQ-025 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=`ALUOp_R; next WB_ALU with RegDst=01.
REQ-026 EXEC_I: ALUSrcA=1, ALUSrcB=10; next WB_ALU with RegDst=00.
- ALUOp: addi ADD, addiu ADDU, slti SLT, sltiu SLTU, andi AND, ori OR, xori XOR.
- ExtOp=1 for addi/addiu/slti/sltiu; ExtOp=0 for andi/ori/xori.
REQ-027 WB_ALU: RegWr=1, MemtoReg=00, RegDst per REQ-025/026; next FETCH. The controller latches the R/I distinction internally.
REQ-028 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=`ALUOp_ADD; next MEM_RD for lw, MEM_WR for sw.
REQ-029 MEM_RD: IorD=1, MemRd=1, hold until mem_ready=1, then WB_MEM. WB_MEM: RegWr=1, RegDst=00, MemtoReg=01, then FETCH.
REQ-030 MEM_WR: IorD=1, MemWr=1, hold until mem_ready=1, then FETCH.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=`ALUOp_SUB, PCSrc=01, PCWr=zero for beq and ~zero for bne; next FETCH.
REQ-032 JUMP: PCSrc=10, PCWr=1. For jal also RegWr=1, RegDst=10, MemtoReg=10. Next FETCH.
REQ-033 mem_ready SHALL be ignored outside FETCH, MEM_RD and MEM_WR.
REQ-034 Latency with mem_ready tied to 1: R/I = 4 cycles, lw = 5, sw = 4, branch = 3, jump = 3. Each wait cycle on mem_ready adds exactly one cycle.

Reset
REQ-035 rst_n=0 SHALL force state to FETCH asynchronously, in any state including mid-access.
REQ-036 While rst_n=0, all write and request strobes SHALL be 0 (PCWr, IRWr, MemRd, MemWr, RegWr, illegal). The first cycle after release SHALL be FETCH with MemRd=1.

Structure
REQ-037 Package mc_ctrl_pkg SHALL hold the state enum, opcode constants, and the RegDst/MemtoReg/ALUSrcB/PCSrc encodings. ALUOp encodings come from ALUOp_Mod.svh.
REQ-038 One combinational sub-module, mc_opdecode, SHALL map opcode to instruction class, I-type ALUOp and ExtOp.

Verification
REQ-039 R-type (opcode 000000), mem_ready=1: states FETCH, DECODE, EXEC_R, WB_ALU; ALUOp=`ALUOp_R in cycle 3; RegWr=1, RegDst=01 in cycle 4 only.
REQ-040 lw with mem_ready=0 for 3 cycles in MEM_RD: MemRd=1, IorD=1 for 4 cycles; WB_MEM in cycle 8 with MemtoReg=01.
REQ-041 beq with zero=1: PCWr=1, PCSrc=01 in cycle 3. bne with zero=1: PCWr stays 0 throughout.
REQ-042 jal: in cycle 3, PCWr=1, PCSrc=10, RegWr=1, RegDst=10, MemtoReg=10; FETCH in cycle 4.
REQ-043 opcode 111111: illegal=1 in cycle 2 only; FETCH in cycle 3; RegWr and MemWr never asserted.
REQ-044 rst_n low mid MEM_WR: MemWr falls immediately; after release, FETCH with MemRd=1 and no stray PCWr.
